bp_cce_inst_fetch: RTL and testbench
====================================

// Module: bp_cce_inst_fetch
// PURPOSE
//  Front end of the CCE microcode pipeline. Holds the microcode instruction RAM and the PC.
//  After reset, the RAM is loaded through a config write port.
//  Then one instruction per cycle is presented to the decoder.
//  On a stall (stall_i from the stall unit), the same instruction is replayed.
//  On a branch resolved by the execute/branch unit, fetch redirects to the target.
// PARAMETERS
//  inst_ram_els_p   256  microcode RAM depth; must be a power of 2
//  inst_width_p     48   microcode instruction width
//  pc_width_lp      $clog2(inst_ram_els_p)  derived; not user-set
// PORTS
//  clk_i             in   1             clock
//  reset_i           in   1             asynchronous, active-high reset
//  cfg_w_v_i         in   1             write the RAM entry at cfg_addr_i (LOAD state only)
//  cfg_addr_i        in   pc_width_lp   config write address
//  cfg_data_i        in   inst_width_p  config write data
//  cfg_done_i        in   1             microcode load complete; start execution at PC 0
//  stall_i           in   1             replay the current instruction next cycle
//  branch_v_i        in   1             current instruction redirects fetch
//  branch_target_i   in   pc_width_lp   redirect target PC
//  inst_o            out  inst_width_p  instruction to the decoder
//  inst_v_o          out  1             inst_o is valid (RUN state only)
//  pc_o              out  pc_width_lp   PC of inst_o
//  state_o           out  2             FSM state, for debug/perfmon
// BEHAVIOUR
//  FSM states and encodings:
//   RESET=0, LOAD=1, PRIME=2, RUN=3.
//  Reset:
//   - reset_i asserted at any time (including mid-RUN): asynchronously state=RESET, pc_o=0,
//     inst_v_o=0, inst_o=0.
//   - RAM contents are NOT cleared by reset.
//   - RESET->LOAD on the first clock edge after reset_i deasserts.
//  LOAD:
//   - cfg_w_v_i writes RAM[cfg_addr_i]<=cfg_data_i on the clock edge.
//   - On cfg_done_i: go to PRIME. A write in the same cycle still completes.
//   - inst_v_o=0 throughout.
//  PRIME:
//   - The RAM reads address 0 (synchronous read, 1-cycle latency).
//   - Always go to RUN next cycle.
//  RUN:
//   - inst_o = registered RAM read data; inst_v_o=1.
//   - pc_o = address that produced inst_o.
//   - Next read address, evaluated combinationally each cycle, in priority order:
//       stall_i            -> pc_o (replay; inst_o and pc_o identical next cycle)
//       else branch_v_i    -> branch_target_i
//       else               -> pc_o+1
//   - pc_o+1 wraps modulo inst_ram_els_p (e.g., 255 -> 0).
//   - Stall and branch in the same cycle: stall wins; the branch is re-evaluated on replay.
//   - There are no bubbles: a taken branch yields the target instruction on the next cycle.
//   - cfg_w_v_i and cfg_done_i are ignored in RUN. The RAM is read-only in RUN.
//   - RUN is left only by reset.
//  Implementation constraints:
//   - The RAM is a single-port synchronous RAM: writes occur only in LOAD, reads in PRIME/RUN.
//   - Combinational path stall_i -> RAM address is allowed; no other input is registered.
// TESTING
//  1. Reset then load: RAM[0..3]=A,B,C,D, then cfg_done_i.
//     -> PRIME for 1 cycle, then inst_o=A/pc_o=0, then B/1, C/2, D/3; inst_v_o=1 from first RUN cycle.
//  2. Stall: stall_i=1 for 3 cycles while pc_o=1.
//     -> inst_o=B, pc_o=1 held for 4 cycles total; then C/2.
//  3. Branch: branch_v_i=1, target=0x80 while pc_o=2.
//     -> next cycle pc_o=0x80, inst_o=RAM[0x80]; then 0x81.
//  4. Stall+branch in the same cycle at pc_o=5 with target 0x10.
//     -> next cycle pc_o=5; if branch_v_i repeats without stall -> pc_o=0x10.
//  5. Wrap: run to pc_o=255 with no stall/branch -> next pc_o=0, inst_o=RAM[0].
//  6. Reset and writes:
//     - Reset asserted mid-RUN -> same cycle inst_v_o=0, pc_o=0.
//     - Re-enter LOAD, skip writes, cfg_done_i -> old RAM contents replay from PC 0.
//     - cfg_w_v_i in RUN -> RAM unchanged.

Source files
------------

// File: rtl/bp_cce_inst_fetch_if.sv
// Fetch-side bus of the CCE microcode front end: config load port, stall/branch
// controls in, instruction stream out.
interface bp_cce_inst_fetch_if #(
  parameter int inst_ram_els_p = 256,
  parameter int inst_width_p   = 48
);
  localparam int pc_width_lp = $clog2(inst_ram_els_p);

  logic                    cfg_w_v_i;
  logic [pc_width_lp-1:0]  cfg_addr_i;
  logic [inst_width_p-1:0] cfg_data_i;
  logic                    cfg_done_i;
  logic                    stall_i;
  logic                    branch_v_i;
  logic [pc_width_lp-1:0]  branch_target_i;
  logic [inst_width_p-1:0] inst_o;
  logic                    inst_v_o;
  logic [pc_width_lp-1:0]  pc_o;
  logic [1:0]              state_o;

  modport master (
    output cfg_w_v_i, cfg_addr_i, cfg_data_i, cfg_done_i,
    output stall_i, branch_v_i, branch_target_i,
    input  inst_o, inst_v_o, pc_o, state_o
  );

  modport slave (
    input  cfg_w_v_i, cfg_addr_i, cfg_data_i, cfg_done_i,
    input  stall_i, branch_v_i, branch_target_i,
    output inst_o, inst_v_o, pc_o, state_o
  );
endinterface

// File: rtl/bp_cce_inst_fetch.sv
// CCE microcode fetch: instruction RAM loaded after reset, then one instruction
// per cycle with stall replay and zero-bubble branch redirect.
//
// state | meaning
// RESET | held in reset; leaves on first edge after reset_i drops
// LOAD  | config writes fill the RAM; cfg_done_i moves on
// PRIME | RAM reads PC 0 so RUN starts with a valid instruction
// RUN   | one instruction per cycle; left only by reset
module bp_cce_inst_fetch #(
  parameter  int inst_ram_els_p = 256,
  parameter  int inst_width_p   = 48,
  localparam int pc_width_lp    = $clog2(inst_ram_els_p)
) (
  input logic               clk_i,
  input logic               reset_i,
  bp_cce_inst_fetch_if.slave fetch
);

  if ((1 << pc_width_lp) != inst_ram_els_p) begin : g_depth_check
    $error("inst_ram_els_p must be a power of 2");
  end

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_LOAD  = 2'd1,
    S_PRIME = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  state_e                  state_r, state_n;
  logic [pc_width_lp-1:0]  pc_r;
  logic [pc_width_lp-1:0]  rd_addr;
  logic                    ram_w_v;
  logic                    ram_r_v;
  logic [inst_width_p-1:0] rdata_r;
  logic [inst_width_p-1:0] mem [inst_ram_els_p];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= S_RESET;
    end else begin
      state_r <= state_n;
    end
  end

  // The stall/branch mux feeds the RAM address directly so a redirect costs no bubble.
  always_comb begin
    state_n = state_r;
    ram_w_v = 1'b0;
    ram_r_v = 1'b0;
    rd_addr = '0;
    unique case (state_r)
      S_RESET: begin
        state_n = S_LOAD;
      end
      S_LOAD: begin
        ram_w_v = fetch.cfg_w_v_i;
        if (fetch.cfg_done_i) begin
          state_n = S_PRIME;
        end
      end
      S_PRIME: begin
        ram_r_v = 1'b1;
        rd_addr = '0;
        state_n = S_RUN;
      end
      S_RUN: begin
        ram_r_v = 1'b1;
        if (fetch.stall_i) begin
          rd_addr = pc_r;
        end else if (fetch.branch_v_i) begin
          rd_addr = fetch.branch_target_i;
        end else begin
          rd_addr = pc_r + pc_width_lp'(1);
        end
      end
      default: begin
        state_n = S_RESET;
      end
    endcase
  end

  // RAM array has no reset: microcode survives a reset and can be replayed without reloading.
  always_ff @(posedge clk_i) begin
    if (ram_w_v) begin
      mem[fetch.cfg_addr_i] <= fetch.cfg_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rdata_r <= '0;
      pc_r    <= '0;
    end else if (ram_r_v) begin
      rdata_r <= mem[rd_addr];
      pc_r    <= rd_addr;
    end
  end

  assign fetch.inst_o   = rdata_r;
  assign fetch.inst_v_o = (state_r == S_RUN);
  assign fetch.pc_o     = pc_r;
  assign fetch.state_o  = state_r;

endmodule

// File: tb/tb_bp_cce_inst_fetch.sv
// Self-checking bench for bp_cce_inst_fetch: directed vector table plus random
// stall/branch traffic against a PC/RAM reference model.
module tb_bp_cce_inst_fetch;
  localparam int ELS = 256;
  localparam int W   = 48;
  localparam int PCW = 8;

  localparam logic [W-1:0] INST_A = 48'hA0A0_0000_000A;
  localparam logic [W-1:0] INST_B = 48'hB0B0_0000_000B;
  localparam logic [W-1:0] INST_C = 48'hC0C0_0000_000C;
  localparam logic [W-1:0] INST_D = 48'hD0D0_0000_000D;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  bp_cce_inst_fetch_if #(.inst_ram_els_p(ELS), .inst_width_p(W)) bus ();

  bp_cce_inst_fetch #(.inst_ram_els_p(ELS), .inst_width_p(W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .fetch   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] model_mem [ELS];
  int exp_pc;

  typedef struct {
    logic           stall;
    logic           branch;
    logic [PCW-1:0] target;
    int             exp_pc;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_run(string tag, int pc);
    chk({tag, " state"}, 64'(bus.state_o), 64'd3);
    chk({tag, " inst_v"}, 64'(bus.inst_v_o), 64'd1);
    chk({tag, " pc"}, 64'(bus.pc_o), 64'(pc));
    chk({tag, " inst"}, 64'(bus.inst_o), 64'(model_mem[pc]));
  endtask

  task automatic clear_inputs();
    bus.cfg_w_v_i       = 1'b0;
    bus.cfg_addr_i      = '0;
    bus.cfg_data_i      = '0;
    bus.cfg_done_i      = 1'b0;
    bus.stall_i         = 1'b0;
    bus.branch_v_i      = 1'b0;
    bus.branch_target_i = '0;
  endtask

  initial begin
    logic [W-1:0] d;
    reset_i = 1'b1;
    clear_inputs();
    tick();
    chk("reset state", 64'(bus.state_o), 64'd0);
    chk("reset inst_v", 64'(bus.inst_v_o), 64'd0);
    chk("reset pc", 64'(bus.pc_o), 64'd0);
    chk("reset inst", 64'(bus.inst_o), 64'd0);

    reset_i = 1'b0;
    tick();
    chk("load state", 64'(bus.state_o), 64'd1);
    chk("load inst_v", 64'(bus.inst_v_o), 64'd0);

    // Fill the RAM; the last write shares its cycle with cfg_done_i
    for (int i = 0; i < ELS; i++) begin
      case (i)
        0:       d = INST_A;
        1:       d = INST_B;
        2:       d = INST_C;
        3:       d = INST_D;
        default: d = W'({$urandom(), $urandom()});
      endcase
      model_mem[i]   = d;
      bus.cfg_w_v_i  = 1'b1;
      bus.cfg_addr_i = PCW'(i);
      bus.cfg_data_i = d;
      bus.cfg_done_i = (i == ELS - 1);
      tick();
      if (i == 100) begin
        chk("mid-load state", 64'(bus.state_o), 64'd1);
        chk("mid-load inst_v", 64'(bus.inst_v_o), 64'd0);
      end
    end
    clear_inputs();
    chk("prime state", 64'(bus.state_o), 64'd2);
    chk("prime inst_v", 64'(bus.inst_v_o), 64'd0);

    tick();
    chk_run("first run", 0);
    chk("first inst A", 64'(bus.inst_o), 64'(INST_A));

    vecs.push_back('{1'b0, 1'b0, 8'h00, 1});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 2});
    vecs.push_back('{1'b0, 1'b1, 8'h80, 8'h80});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h81});
    vecs.push_back('{1'b0, 1'b1, 8'h05, 5});
    vecs.push_back('{1'b1, 1'b1, 8'h10, 5});
    vecs.push_back('{1'b0, 1'b1, 8'h10, 8'h10});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h11});
    vecs.push_back('{1'b0, 1'b1, 8'hFE, 8'hFE});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 8'hFF});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 2});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 3});

    foreach (vecs[k]) begin
      bus.stall_i         = vecs[k].stall;
      bus.branch_v_i      = vecs[k].branch;
      bus.branch_target_i = vecs[k].target;
      tick();
      chk_run($sformatf("vec%0d", k), vecs[k].exp_pc);
    end
    chk("vec D at pc3", 64'(bus.inst_o), 64'(INST_D));
    exp_pc = 3;

    // Random traffic, including config writes that RUN must ignore
    for (int n = 0; n < 400; n++) begin
      logic s, b;
      logic [PCW-1:0] t;
      s = ($urandom_range(3) == 0);
      b = ($urandom_range(4) == 0);
      t = PCW'($urandom_range(ELS - 1));
      bus.stall_i         = s;
      bus.branch_v_i      = b;
      bus.branch_target_i = t;
      bus.cfg_w_v_i       = ($urandom_range(1) == 1);
      bus.cfg_addr_i      = ($urandom_range(1) == 1) ? PCW'($urandom_range(3))
                                                     : PCW'($urandom_range(ELS - 1));
      bus.cfg_data_i      = W'({$urandom(), $urandom()});
      bus.cfg_done_i      = ($urandom_range(1) == 1);
      if (s)      exp_pc = exp_pc;
      else if (b) exp_pc = int'(t);
      else        exp_pc = (exp_pc + 1) % ELS;
      tick();
      chk_run($sformatf("rand%0d", n), exp_pc);
    end
    clear_inputs();

    // Asynchronous reset mid-cycle in RUN
    #2;
    reset_i = 1'b1;
    #1;
    chk("async reset state", 64'(bus.state_o), 64'd0);
    chk("async reset inst_v", 64'(bus.inst_v_o), 64'd0);
    chk("async reset pc", 64'(bus.pc_o), 64'd0);
    chk("async reset inst", 64'(bus.inst_o), 64'd0);
    tick();
    reset_i = 1'b0;
    tick();
    chk("reload state", 64'(bus.state_o), 64'd1);
    bus.cfg_done_i = 1'b1;
    tick();
    bus.cfg_done_i = 1'b0;
    chk("reprime state", 64'(bus.state_o), 64'd2);
    tick();
    chk_run("replay0", 0);
    chk("replay inst A", 64'(bus.inst_o), 64'(INST_A));
    tick();
    chk("replay inst B", 64'(bus.inst_o), 64'(INST_B));
    tick();
    chk("replay inst C", 64'(bus.inst_o), 64'(INST_C));
    tick();
    chk_run("replay3", 3);
    chk("replay inst D", 64'(bus.inst_o), 64'(INST_D));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
